mem_wb_stage: RTL
=================

# mem_wb_stage

Combined memory-access and writeback stage of the five-stage RISC-V pipeline. Accepts one executed instruction per cycle, performs a word load/store against data memory over a request/acknowledge handshake, and drives the register-file write port (WB_WE, WB_A, WB_D) consumed by the decode stage. It stalls upstream while a memory access is outstanding and flags misaligned or timed-out accesses.

## Interface
- TIMEOUT, 255: max cycles DM_REQ may stay high without DM_ACK before the access is aborted (1..255).
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- EX_VALID  in  1  instruction presented this cycle.
- ALU_RES  in  `INST_SIZE  ALU result; memory address for load/store, writeback data otherwise.
- STORE_D  in  `INST_SIZE  store data (rs2).
- RD_A  in  `REG_NUM_SIZE  destination register.
- MEM_WE  in  1  store.
- MEM_REG  in  1  load (writeback from memory).
- DE_WE  in  1  register write enable.
- STALL  out  1  upstream must hold EX_* inputs stable.
- DM_REQ  out  1  memory request.
- DM_WE  out  1  request is a write.
- DM_ADDR  out  `INST_SIZE  word address (byte-addressed, [1:0]=0).
- DM_WD  out  `INST_SIZE  write data.
- DM_ACK  in  1  memory completes current request.
- DM_RD  in  `INST_SIZE  read data, valid in DM_ACK cycle.
- WB_WE  out  1  register-file write, one-cycle pulse.
- WB_A  out  `REG_NUM_SIZE  write address.
- WB_D  out  `INST_SIZE  write data.
- MEM_ERR  out  1  sticky error flag.

## Operation
- States: IDLE, MEM_WAIT. STALL = (state == MEM_WAIT).
- IDLE, EX_VALID, neither MEM_WE nor MEM_REG: next cycle WB_WE = DE_WE && RD_A != 0, WB_A = RD_A, WB_D = ALU_RES.
- IDLE, EX_VALID, MEM_WE or MEM_REG, ALU_RES[1:0]==0: capture RD_A, DE_WE, MEM_REG, address, data; -> MEM_WAIT; DM_REQ=1, DM_WE=MEM_WE from next cycle.
- Misaligned (ALU_RES[1:0]!=0) memory op: no request, no writeback, MEM_ERR set; stay IDLE.
- MEM_WAIT: DM_REQ, DM_WE, DM_ADDR, DM_WD held constant until DM_ACK. On DM_ACK: -> IDLE; if load, WB_WE = DE_WE && RD_A != 0, WB_D = DM_RD (registered) next cycle; store produces no writeback.
- Watchdog counts MEM_WAIT cycles; on reaching TIMEOUT without ACK: drop DM_REQ, -> IDLE, set MEM_ERR, no writeback. ACK in the same cycle as expiry wins (normal completion).
- MEM_REG and MEM_WE both set: treated as store; no writeback.
- EX_VALID while STALL: ignored (upstream holds). DM_ACK in IDLE: ignored.
- x0 never written: WB_WE forced 0 when RD_A == 0.
- MEM_ERR cleared only by rst.

## Timing
- Reset (async, immediate): state IDLE, STALL 0, DM_REQ 0, DM_WE 0, DM_ADDR 0, DM_WD 0, WB_WE 0, WB_A 0, WB_D 0, MEM_ERR 0, watchdog 0. Reset mid-access drops DM_REQ the same instant; memory must discard it.
- Non-memory op: accepted cycle n, WB pulse cycle n+1.
- Memory op: accepted n; DM_REQ and STALL high n+1; ACK in cycle m ≥ n+1; WB pulse (load) and STALL low at m+1; next instruction accepted at m+1. Minimum load latency 2 cycles.
- All outputs registered; no combinational path from inputs to outputs.
- WB write lands in the register file at the rising edge ending the pulse cycle.

## Structure
- Shared package/include: `INST_SIZE, `REG_NUM_SIZE, `INST_SIZE_ZEROS, state encoding localparams.
- One sub-module: dm_watchdog (8-bit counter; inputs clear/enable, output expired at TIMEOUT).

## Test plan
- ALU op RD_A=5, ALU_RES=0x1234, DE_WE=1 at cycle n -> WB_WE=1, WB_A=5, WB_D=0x1234 at n+1 only; STALL never high.
- Load ALU_RES=0x100, RD_A=3, ACK after 3 cycles with DM_RD=0xDEADBEEF -> DM_REQ held 3 cycles at DM_ADDR=0x100, STALL high 3 cycles, WB_D=0xDEADBEEF to x3 the cycle after ACK.
- Store ALU_RES=0x40, STORE_D=0xA5A5A5A5, immediate ACK -> one DM_REQ cycle with DM_WE=1, DM_WD=0xA5A5A5A5; no WB_WE.
- Load to RD_A=0 and load at ALU_RES=0x102 -> first: request made, WB_WE stays 0; second: no DM_REQ, MEM_ERR=1.
- TIMEOUT=4, never ACK -> DM_REQ drops after 4 cycles, MEM_ERR=1, no WB; repeat with ACK on 4th cycle -> normal completion, MEM_ERR stays 0.
- rst asserted while DM_REQ=1 -> DM_REQ, STALL, WB_WE, MEM_ERR zero immediately; first post-reset ALU op writes back normally.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared widths, state encoding and helpers for mem_wb_stage
//
// Purpose : common definitions for the memory-access / writeback stage.
// Contents: INST_SIZE, REG_NUM_SIZE, INST_SIZE_ZEROS, WDOG_WIDTH,
//           state_t encoding, mem_ctx_t captured-access context,
//           is_aligned() word-alignment helper.
package mem_wb_stage_pkg;

    localparam int INST_SIZE    = 32;
    localparam int REG_NUM_SIZE = 5;
    localparam int WDOG_WIDTH   = 8;

    localparam logic [INST_SIZE-1:0] INST_SIZE_ZEROS = '0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Everything about an in-flight access that is needed when it completes.
    typedef struct packed {
        logic [REG_NUM_SIZE-1:0] rd;
        logic                    de_we;
        logic                    load;
        logic                    we;
    } mem_ctx_t;

    function automatic logic is_aligned(input logic [INST_SIZE-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_watchdog.sv
// rtl/mem_wb_stage_dm_watchdog.sv - data-memory access watchdog counter
//
// Purpose : counts cycles spent waiting for DM_ACK and flags expiry.
// Ports   : clk, rst      - clock, async active-high reset
//           clear         - force count to zero (stage idle)
//           enable        - count this cycle (stage waiting on memory)
//           expired       - current wait cycle is the TIMEOUT-th one
module dm_watchdog
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count holds the number of wait cycles already completed, so the
    // TIMEOUT-th wait cycle is the one where count == TIMEOUT-1.
    localparam logic [WDOG_WIDTH-1:0] LIMIT = WDOG_WIDTH'(TIMEOUT - 1);

    logic [WDOG_WIDTH-1:0] count;

    assign expired = enable && (count == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - combined memory-access and writeback pipeline stage
//
// Purpose : takes one executed instruction per cycle, performs word loads and
//           stores over a REQ/ACK handshake and drives the register-file
//           write port. Stalls upstream while an access is outstanding.
// Ports   : clk, rst                         - clock, async active-high reset
//           EX_VALID, ALU_RES, STORE_D, RD_A,
//           MEM_WE, MEM_REG, DE_WE           - executed instruction
//           STALL                            - upstream must hold inputs
//           DM_REQ, DM_WE, DM_ADDR, DM_WD,
//           DM_ACK, DM_RD                    - data-memory handshake
//           WB_WE, WB_A, WB_D                - register-file write port
//           MEM_ERR                          - sticky misalign/timeout flag
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    EX_VALID,
    input  logic [INST_SIZE-1:0]    ALU_RES,
    input  logic [INST_SIZE-1:0]    STORE_D,
    input  logic [REG_NUM_SIZE-1:0] RD_A,
    input  logic                    MEM_WE,
    input  logic                    MEM_REG,
    input  logic                    DE_WE,
    output logic                    STALL,
    output logic                    DM_REQ,
    output logic                    DM_WE,
    output logic [INST_SIZE-1:0]    DM_ADDR,
    output logic [INST_SIZE-1:0]    DM_WD,
    input  logic                    DM_ACK,
    input  logic [INST_SIZE-1:0]    DM_RD,
    output logic                    WB_WE,
    output logic [REG_NUM_SIZE-1:0] WB_A,
    output logic [INST_SIZE-1:0]    WB_D,
    output logic                    MEM_ERR
);

    state_t   state;
    state_t   next_state;
    mem_ctx_t ctx;

    logic accept_alu;
    logic accept_mem;
    logic misaligned;
    logic finish;
    logic timeout;
    logic expired;
    logic waiting;

    assign waiting = (state == ST_MEM_WAIT);

    dm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        next_state = state;
        accept_alu = 1'b0;
        accept_mem = 1'b0;
        misaligned = 1'b0;
        finish     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EX_VALID) begin
                    if (MEM_WE || MEM_REG) begin
                        if (is_aligned(ALU_RES)) begin
                            accept_mem = 1'b1;
                            next_state = ST_MEM_WAIT;
                        end else begin
                            misaligned = 1'b1;
                        end
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // An ACK arriving on the expiry cycle still completes normally.
                if (DM_ACK) begin
                    finish     = 1'b1;
                    next_state = ST_IDLE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs come straight from state/context registers, so a
    // reset drops DM_REQ and STALL immediately.
    always_comb begin
        STALL  = waiting;
        DM_REQ = waiting;
        DM_WE  = waiting && ctx.we;
    end

    // Access context, memory address/data and writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx     <= '0;
            DM_ADDR <= INST_SIZE_ZEROS;
            DM_WD   <= INST_SIZE_ZEROS;
            WB_WE   <= 1'b0;
            WB_A    <= '0;
            WB_D    <= INST_SIZE_ZEROS;
            MEM_ERR <= 1'b0;
        end else begin
            WB_WE <= 1'b0;

            if (accept_alu) begin
                WB_WE <= DE_WE && (RD_A != '0);
                WB_A  <= RD_A;
                WB_D  <= ALU_RES;
            end

            if (accept_mem) begin
                // A combined load+store is treated as a plain store.
                ctx <= '{rd:    RD_A,
                         de_we: DE_WE,
                         load:  MEM_REG && !MEM_WE,
                         we:    MEM_WE};
                DM_ADDR <= ALU_RES;
                DM_WD   <= STORE_D;
            end

            if (finish && ctx.load) begin
                WB_WE <= ctx.de_we && (ctx.rd != '0);
                WB_A  <= ctx.rd;
                WB_D  <= DM_RD;
            end

            if (misaligned || timeout) begin
                MEM_ERR <= 1'b1;
            end
        end
    end

endmodule
